aes_decrypt_core: RTL



---
 rtl/aes_decrypt_core.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: expands the key schedule in-block, then applies one inverse round per clock.
// Optional macro AES_KEY_CACHE_EN: reuse the stored schedule when the same key is started again.
//
//  state  | meaning
//  IDLE   | waiting for AES_START; captures key and ciphertext
//  KEYEXP | derives one round key per cycle, rk[1]..rk[NR]
//  INIT   | initial AddRoundKey with rk[NR]
//  ROUND  | full inverse rounds NR-1 down to 1
//  FINAL  | last inverse round without InvMixColumns; result registered
//  DONE   | AES_DONE high until AES_START drops
module aes_decrypt_core #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             AES_START,
  input  logic [KEY_W-1:0] AES_KEY,
  input  logic [KEY_W-1:0] AES_MSG_ENC,
  output logic [KEY_W-1:0] AES_MSG_DEC,
  output logic             AES_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYEXP,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_RK = 4'(NR);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] y;
    r = 8'h01;
    y = a;
    for (int i = 1; i < 8; i++) begin
      y = gf_mul(y, y);
      r = gf_mul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] inv_mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e           fsm_q;
  logic [3:0]       rnd_q;
  logic [KEY_W-1:0] st_q;
  logic [KEY_W-1:0] msg_q;
  logic [KEY_W-1:0] dec_q;
  logic             done_q;
  logic [KEY_W-1:0] rk_q [0:NR];
`ifdef AES_KEY_CACHE_EN
  logic             vld_q;
`endif

  // Key expansion step: rk[rnd_q] from rk[rnd_q-1]
  logic [3:0]   kidx;
  logic [127:0] kx_prev;
  logic [31:0]  kx_rot;
  logic [31:0]  kx_sub;
  logic [31:0]  kx_t;
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [127:0] kx_next;

  assign kidx    = (rnd_q == 4'd0) ? 4'd0 : rnd_q - 4'd1;
  assign kx_prev = rk_q[kidx];
  assign kx_rot  = {kx_prev[23:0], kx_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign kx_sub[8*g+7:8*g] = sbox(kx_rot[8*g+7:8*g]);
  end

  assign kx_t    = kx_sub ^ {rcon(rnd_q), 24'h000000};
  assign kw0     = kx_prev[127:96] ^ kx_t;
  assign kw1     = kx_prev[95:64] ^ kw0;
  assign kw2     = kx_prev[63:32] ^ kw1;
  assign kw3     = kx_prev[31:0] ^ kw2;
  assign kx_next = {kw0, kw1, kw2, kw3};

  // Inverse round datapath; FINAL reuses it with rnd_q == 0 selecting rk[0]
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = r + 4 * c;
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign isb[127-8*DST -: 8] = inv_sbox(st_q[127-8*SRC -: 8]);
    end
    assign imc[127-32*c -: 32] = inv_mixcol(ark[127-32*c -: 32]);
  end

  assign ark = isb ^ rk_q[rnd_q];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fsm_q  <= S_IDLE;
      rnd_q  <= 4'd0;
      st_q   <= '0;
      msg_q  <= '0;
      dec_q  <= '0;
      done_q <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
`ifdef AES_KEY_CACHE_EN
      vld_q  <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (AES_START) begin
            msg_q <= AES_MSG_ENC;
`ifdef AES_KEY_CACHE_EN
            if (vld_q && (AES_KEY == rk_q[0])) begin
              fsm_q <= S_INIT;
            end else begin
              rk_q[0] <= AES_KEY;
              vld_q   <= 1'b0;
              rnd_q   <= 4'd1;
              fsm_q   <= S_KEYEXP;
            end
`else
            rk_q[0] <= AES_KEY;
            rnd_q   <= 4'd1;
            fsm_q   <= S_KEYEXP;
`endif
          end
        end
        S_KEYEXP: begin
          rk_q[rnd_q] <= kx_next;
          if (rnd_q == LAST_RK) begin
            fsm_q <= S_INIT;
`ifdef AES_KEY_CACHE_EN
            vld_q <= 1'b1;
`endif
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        S_INIT: begin
          st_q  <= msg_q ^ rk_q[NR];
          rnd_q <= LAST_RK - 4'd1;
          fsm_q <= S_ROUND;
        end
        S_ROUND: begin
          st_q  <= imc;
          rnd_q <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) fsm_q <= S_FINAL;
        end
        S_FINAL: begin
          dec_q  <= ark;
          done_q <= 1'b1;
          fsm_q  <= S_DONE;
        end
        S_DONE: begin
          if (!AES_START) begin
            done_q <= 1'b0;
            fsm_q  <= S_IDLE;
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign AES_MSG_DEC = dec_q;
  assign AES_DONE    = done_q;

endmodule
